// File: rtl/qspi_mem_pkg.sv
// rtl/qspi_mem_pkg.sv - shared state and command constants for the QSPI memory slave
package qspi_mem_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_DUMMY  = 3'd3;
    localparam state_t ST_READ   = 3'd4;
    localparam state_t ST_WRITE  = 3'd5;
    localparam state_t ST_IGNORE = 3'd6;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

endpackage

// File: rtl/qspi_mem_slave_sync_edge.sv
// rtl/qspi_mem_slave_sync_edge.sv - 2-FF synchroniser with one-cycle rise/fall pulses
module sync_edge #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= {WIDTH{RESET_VAL}};
            s2   <= {WIDTH{RESET_VAL}};
            prev <= {WIDTH{RESET_VAL}};
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/qspi_mem_slave.sv
// rtl/qspi_mem_slave.sv - oversampled quad-SPI ROM/RAM slave with read (0x03) and write (0x02)
module qspi_mem_slave
    import qspi_mem_pkg::*;
#(
    parameter int    MEM_BYTES  = 65536,
    parameter string INIT_FILE  = "",
    parameter int    WRITABLE   = 1,
    parameter int    READ_DUMMY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_csb,
    input  logic       spi_sck,
    input  logic [3:0] spi_io_in,
    output logic [3:0] spi_io_out,
    output logic [3:0] spi_io_oe
);

    localparam int         AW         = $clog2(MEM_BYTES);
    localparam logic [7:0] DUMMY_LAST = 8'(READ_DUMMY - 1);

    logic       csb_q, csb_fall, csb_rise_unused;
    logic       sck_rise, sck_fall, sck_q_unused;
    logic [3:0] io_q, io_rise_unused, io_fall_unused;

    // csb idles high so the synchroniser must not report a fall out of reset
    sync_edge #(.WIDTH(1), .RESET_VAL(1'b1)) u_csb (
        .clk(clk), .rst(rst), .d(spi_csb),
        .q(csb_q), .rise(csb_rise_unused), .fall(csb_fall)
    );

    sync_edge #(.WIDTH(1), .RESET_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .d(spi_sck),
        .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.WIDTH(4), .RESET_VAL(1'b0)) u_io (
        .clk(clk), .rst(rst), .d(spi_io_in),
        .q(io_q), .rise(io_rise_unused), .fall(io_fall_unused)
    );

    logic [7:0]    mem [MEM_BYTES];
    state_t        state;
    logic [7:0]    cnt;
    logic [19:0]   sh;
    logic          is_write;
    logic [AW-1:0] addr;
    logic          rd_lo;
    logic          wr_lo;
    logic [3:0]    wr_hi;
    logic [7:0]    wr_byte;
    logic          wr_pend;
    logic          oe;
    logic [3:0]    io_out_r;

    logic [23:0] addr_full;
    logic [7:0]  cmd_byte;
    logic [7:0]  rd_byte;

    assign addr_full = {sh, io_q};
    assign cmd_byte  = {sh[3:0], io_q};
    assign rd_byte   = mem[addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            sh       <= 20'd0;
            is_write <= 1'b0;
            addr     <= '0;
            rd_lo    <= 1'b0;
            wr_lo    <= 1'b0;
            wr_hi    <= 4'd0;
            wr_byte  <= 8'd0;
            wr_pend  <= 1'b0;
            oe       <= 1'b0;
            io_out_r <= 4'd0;
        end else begin
            // a completed byte commits one cycle after its low nibble, even if csb rises meanwhile
            if (wr_pend) begin
                addr    <= addr + AW'(1);
                wr_pend <= 1'b0;
            end
            if (csb_q) begin
                state    <= ST_IDLE;
                oe       <= 1'b0;
                io_out_r <= 4'd0;
                cnt      <= 8'd0;
                rd_lo    <= 1'b0;
                wr_lo    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (csb_fall) begin
                            state <= ST_CMD;
                            cnt   <= 8'd0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            sh  <= {sh[15:0], io_q};
                            cnt <= cnt + 8'd1;
                            if (cnt == 8'd1) begin
                                cnt <= 8'd0;
                                if (cmd_byte == CMD_READ) begin
                                    state    <= ST_ADDR;
                                    is_write <= 1'b0;
                                end else if (cmd_byte == CMD_WRITE) begin
                                    state    <= ST_ADDR;
                                    is_write <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            sh  <= {sh[15:0], io_q};
                            cnt <= cnt + 8'd1;
                            if (cnt == 8'd5) begin
                                addr <= addr_full[AW-1:0];
                                cnt  <= 8'd0;
                                if (is_write)
                                    state <= ST_WRITE;
                                else
                                    state <= (READ_DUMMY == 0) ? ST_READ : ST_DUMMY;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == DUMMY_LAST) begin
                                cnt   <= 8'd0;
                                state <= ST_READ;
                            end
                        end
                    end
                    ST_READ: begin
                        if (sck_fall) begin
                            oe <= 1'b1;
                            if (!rd_lo) begin
                                io_out_r <= rd_byte[7:4];
                                rd_lo    <= 1'b1;
                            end else begin
                                io_out_r <= rd_byte[3:0];
                                rd_lo    <= 1'b0;
                                addr     <= addr + AW'(1);
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (sck_rise) begin
                            if (!wr_lo) begin
                                wr_hi <= io_q;
                                wr_lo <= 1'b1;
                            end else begin
                                wr_byte <= {wr_hi, io_q};
                                wr_pend <= 1'b1;
                                wr_lo   <= 1'b0;
                            end
                        end
                    end
                    ST_IGNORE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    generate
        if (WRITABLE != 0) begin : g_wr
            always_ff @(posedge clk) begin
                if (wr_pend)
                    mem[addr] <= wr_byte;
            end
        end
    endgenerate

    assign spi_io_out = io_out_r;
    assign spi_io_oe  = {4{oe}};

endmodule

// File: tb/tb_qspi_mem_slave.sv
// tb/tb_qspi_mem_slave.sv - randomized model-checked bench for a ROM and a RAM instance on one bus
module tb_qspi_mem_slave;

    logic       clk;
    logic       rst;
    logic       csb_rom, csb_ram;
    logic       sck;
    logic [3:0] io_in;
    logic [3:0] rom_io, rom_oe, ram_io, ram_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [2][256];
    bit         m_oe [2];
    logic [3:0] m_io [2];
    logic [4:0] got [$];

    qspi_mem_slave #(.MEM_BYTES(256), .WRITABLE(0), .READ_DUMMY(2)) u_rom (
        .clk(clk), .rst(rst), .spi_csb(csb_rom), .spi_sck(sck),
        .spi_io_in(io_in), .spi_io_out(rom_io), .spi_io_oe(rom_oe)
    );

    qspi_mem_slave #(.MEM_BYTES(256), .WRITABLE(1), .READ_DUMMY(0)) u_ram (
        .clk(clk), .rst(rst), .spi_csb(csb_ram), .spi_sck(sck),
        .spi_io_in(io_in), .spi_io_out(ram_io), .spi_io_oe(ram_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pin edges happen on negedge; the slave must answer exactly three posedges later.
    logic [4:0] pipe [2][3];
    initial begin
        for (int s = 0; s < 2; s++)
            for (int j = 0; j < 3; j++) pipe[s][j] = 5'd0;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                logic [3:0] a_oe, a_io;
                pipe[s][2] = pipe[s][1];
                pipe[s][1] = pipe[s][0];
                pipe[s][0] = {m_oe[s], m_io[s]};
                a_oe = (s == 1) ? ram_oe : rom_oe;
                a_io = (s == 1) ? ram_io : rom_io;
                chk(s == 1 ? "ram_oe" : "rom_oe", 32'(a_oe), 32'({4{pipe[s][2][4]}}));
                if (pipe[s][2][4])
                    chk(s == 1 ? "ram_io" : "rom_io", 32'(a_io), 32'(pipe[s][2][3:0]));
            end
        end
    end

    function automatic logic [3:0] nib_at(input int s, input logic [23:0] a, input int k);
        logic [7:0] b;
        b = mm[s][(int'(a) + k / 2) % 256];
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic clock_nib(input int s, input logic [3:0] n, input bit cap,
                             input bit upd, input logic [3:0] fnib);
        io_in = n;
        half();
        if (cap) got.push_back(s == 1 ? {ram_oe[0], ram_io} : {rom_oe[0], rom_io});
        sck = 1'b1;
        half();
        sck = 1'b0;
        if (upd) begin
            m_oe[s] = 1'b1;
            m_io[s] = fnib;
        end
    endtask

    task automatic start_frame(input int s);
        @(negedge clk);
        if (s == 1) csb_ram = 1'b0; else csb_rom = 1'b0;
        half();
    endtask

    task automatic end_frame(input int s);
        half();
        if (s == 1) csb_ram = 1'b1; else csb_rom = 1'b1;
        m_oe[s] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("oe_off", 32'(s == 1 ? ram_oe : rom_oe), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic read_frame(input int s, input logic [23:0] addr, input int nnib);
        logic [31:0] hdr_word;
        int hdr;
        hdr_word = {8'h03, addr};
        hdr = 8 + ((s == 1) ? 0 : 2);
        got.delete();
        start_frame(s);
        for (int c = 0; c < hdr + nnib; c++) begin
            logic [3:0] n;
            int k;
            n = (c < 8) ? hdr_word[31 - 4 * c -: 4] : 4'($urandom);
            k = c - (hdr - 1);
            clock_nib(s, n, c >= hdr, k >= 0, (k >= 0) ? nib_at(s, addr, k) : 4'd0);
        end
        end_frame(s);
    endtask

    task automatic write_frame(input int s, input logic [23:0] addr,
                               input logic [7:0] d[$], input bit partial);
        logic [31:0] hdr_word;
        hdr_word = {8'h02, addr};
        start_frame(s);
        for (int c = 0; c < 8; c++) clock_nib(s, hdr_word[31 - 4 * c -: 4], 1'b0, 1'b0, 4'd0);
        foreach (d[i]) begin
            clock_nib(s, d[i][7:4], 1'b0, 1'b0, 4'd0);
            clock_nib(s, d[i][3:0], 1'b0, 1'b0, 4'd0);
        end
        if (partial) clock_nib(s, 4'($urandom), 1'b0, 1'b0, 4'd0);
        end_frame(s);
        if (s == 1)
            foreach (d[i]) mm[1][(int'(addr) + i) % 256] = d[i];
    endtask

    task automatic ignore_frame(input int s, input logic [7:0] cmd, input int extra);
        start_frame(s);
        clock_nib(s, cmd[7:4], 1'b0, 1'b0, 4'd0);
        clock_nib(s, cmd[3:0], 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < extra; i++) clock_nib(s, 4'($urandom), 1'b0, 1'b0, 4'd0);
        end_frame(s);
    endtask

    task automatic check_got(input string nm, input logic [19:0] e, input int n);
        chk({nm, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < got.size()) chk(nm, 32'(got[i]), 32'(e[19 - 5 * i -: 5]));
    endtask

    initial begin
        logic [7:0] d [$];
        rst = 1'b1; csb_rom = 1'b1; csb_ram = 1'b1; sck = 1'b0; io_in = 4'd0;
        m_oe[0] = 1'b0; m_oe[1] = 1'b0; m_io[0] = 4'd0; m_io[1] = 4'd0;
        for (int i = 0; i < 256; i++) begin
            mm[0][i] = 8'($urandom);
            if (i == 0) mm[0][i] = 8'hA5;
            if (i == 1) mm[0][i] = 8'h3C;
            u_rom.mem[i] = mm[0][i];
        end

        repeat (3) @(negedge clk);
        chk("rst_rom_oe", 32'(rom_oe), 32'd0);
        chk("rst_rom_io", 32'(rom_io), 32'd0);
        chk("rst_ram_oe", 32'(ram_oe), 32'd0);
        chk("rst_ram_io", 32'(ram_io), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_rom_oe", 32'(rom_oe), 32'd0);
        chk("post_rst_ram_io", 32'(ram_io), 32'd0);

        // RAM contents come from the write path itself
        d.delete();
        for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
        d[0] = 8'hC3; d[8'h20] = 8'h77; d[8'hFF] = 8'h5A;
        write_frame(1, 24'h000000, d, 1'b0);

        read_frame(0, 24'h000000, 4);
        check_got("rom_read", {5'h1A, 5'h15, 5'h13, 5'h1C}, 4);

        d.delete(); d.push_back(8'h11); d.push_back(8'h22);
        write_frame(1, 24'h000010, d, 1'b0);
        read_frame(1, 24'h000010, 4);
        check_got("ram_rw", {5'h11, 5'h11, 5'h12, 5'h12}, 4);

        read_frame(1, 24'hABCDFF, 4);
        check_got("wrap", {5'h15, 5'h1A, 5'h1C, 5'h13}, 4);

        d.delete();
        write_frame(1, 24'h000020, d, 1'b1);
        read_frame(1, 24'h000020, 2);
        check_got("abort", {5'h17, 5'h17, 10'd0}, 2);

        d.delete(); d.push_back(8'hFF);
        write_frame(0, 24'h000000, d, 1'b0);
        read_frame(0, 24'h000000, 2);
        check_got("rom_wp", {5'h1A, 5'h15, 10'd0}, 2);

        ignore_frame(0, 8'h9F, 12);
        read_frame(0, 24'h000000, 2);
        check_got("after_ign", {5'h1A, 5'h15, 10'd0}, 2);

        for (int it = 0; it < 40; it++) begin
            int s, r;
            logic [23:0] a;
            logic [7:0] c;
            s = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            a = 24'($urandom);
            if (r < 5) begin
                read_frame(s, a, int'($urandom_range(1, 16)));
            end else if (r < 8) begin
                d.delete();
                for (int i = 0; i < int'($urandom_range(0, 4)); i++) d.push_back(8'($urandom));
                write_frame(s, a, d, 1'($urandom));
            end else begin
                c = 8'($urandom);
                if (c == 8'h02 || c == 8'h03) c = 8'h9F;
                ignore_frame(s, c, int'($urandom_range(0, 10)));
            end
        end

        read_frame(1, 24'h000000, 512);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
